// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data-memory port.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_bus_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two masters, with
// address-window decode, fixed-length memory access and Ack/Err response pulses.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE        = 32'h0000_0500,
  parameter logic [31:0] LIMIT       = 32'h0000_08FF
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last, last_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_we, lat_we_nxt;
  logic [31:0] lat_addr, lat_addr_nxt;
  logic [31:0] lat_wdata, lat_wdata_nxt;
  logic [31:0] rdata0, rdata1;

  // Candidate selection: a lone request wins, a tie goes to the master that was not served last.
  logic        pick;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_window;

  always_comb begin
    pick      = (bus.req0 && bus.req1) ? ~last : bus.req1;
    sel_we    = pick ? bus.we1    : bus.we0;
    sel_addr  = pick ? bus.addr1  : bus.addr0;
    sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    in_window = (sel_addr >= BASE) && (sel_addr <= LIMIT);
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    last_nxt      = last;
    cnt_nxt       = cnt;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_nxt       = pick;
          last_nxt      = pick;
          lat_we_nxt    = sel_we;
          lat_addr_nxt  = sel_addr;
          lat_wdata_nxt = sel_wdata;
          cnt_nxt       = 4'(WAIT_CYCLES - 1);
          state_nxt     = in_window ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      last      <= last_nxt;
      cnt       <= cnt_nxt;
      lat_we    <= lat_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
    end
  end

  // Read data is taken on the last access cycle straight into the served master's
  // register, so it is already valid in the Ack cycle and holds until the next read Ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && cnt == 4'd0 && !lat_we) begin
      if (gnt) rdata1 <= bus.mem_rdata;
      else     rdata0 <= bus.mem_rdata;
    end
  end

  // Moore outputs; mem_cs follows the asynchronously reset state register.
  assign bus.mem_cs    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && lat_we;
  assign bus.mem_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign bus.mem_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign bus.ack0      = (state == RESP) && !gnt;
  assign bus.ack1      = (state == RESP) &&  gnt;
  assign bus.err0      = (state == ERR)  && !gnt;
  assign bus.err1      = (state == ERR)  &&  gnt;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;

endmodule
